// File: rtl/contador_mod_n.sv
// contador_mod_n: modulo-N down-counter digit with clamped load, wrap/hold, load-error and expiry flags.
// Define CONTADOR_UPDOWN_EN to add the `up` port for up/down counting.
module contador_mod_n #(
  parameter int MODULUS   = 10,
  parameter int WIDTH     = 4,
  parameter int WRAP_MODE = 1
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic             en,
  input  logic             loadn,
`ifdef CONTADOR_UPDOWN_EN
  input  logic             up,
`endif
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero,
  output logic             load_err,
  output logic             expired
);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
  if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("contador_mod_n: MODULUS must lie in 2..2**WIDTH");
  end
  logic             dir_up;
  logic             at_end;
  logic             clamp;
  logic             hit;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] nxt;
`ifdef CONTADOR_UPDOWN_EN
  assign dir_up = up;
`else
  assign dir_up = 1'b0;
`endif
  assign zero   = count == '0;
  // the terminal value depends on direction: 0 going down, MODULUS-1 going up
  assign at_end = dir_up ? count == MAX : zero;
  assign tc     = en & loadn & at_end;
  assign clamp  = {1'b0, data} >= MOD_X;
  always_comb begin
    step = dir_up ? count + 1'b1 : count - 1'b1;
    nxt  = at_end ? (WRAP_MODE != 0 ? (dir_up ? '0 : MAX) : count) : step;
    hit  = !at_end && (dir_up ? step == MAX : step == '0);
  end
  always_ff @(posedge clk or negedge clearn)
    if (!clearn) begin
      count    <= '0;
      load_err <= 1'b0;
      expired  <= 1'b0;
    end else if (!loadn) begin
      count    <= clamp ? MAX : data;
      load_err <= clamp;
      expired  <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (en) begin
        count <= nxt;
        if (hit) expired <= 1'b1;
      end
    end
endmodule

// File: tb/tb_contador_mod_n.sv
// tb_contador_mod_n: randomized scoreboard bench for mod-6 wrap/hold digits and a 60-state two-digit cascade.
module tb_contador_mod_n;
  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       en = 1'b0;
  logic       loadn = 1'b1;
  logic [2:0] d3 = '0;
  logic [3:0] d_lo = '0;
  logic [2:0] d_hi = '0;
  logic [2:0] c6w, c6h, c_hi;
  logic [3:0] c_lo;
  logic tc6w, tc6h, tc_lo, tc_hi, z6w, z6h, z_lo, z_hi;
  logic le6w, le6h, le_lo, le_hi, ex6w, ex6h, ex_lo, ex_hi;

  always #5 clk = ~clk;

  contador_mod_n #(.MODULUS(6), .WIDTH(3), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .clearn(clearn), .en(en), .loadn(loadn), .data(d3),
    .count(c6w), .tc(tc6w), .zero(z6w), .load_err(le6w), .expired(ex6w));
  contador_mod_n #(.MODULUS(6), .WIDTH(3), .WRAP_MODE(0)) u_hold (
    .clk(clk), .clearn(clearn), .en(en), .loadn(loadn), .data(d3),
    .count(c6h), .tc(tc6h), .zero(z6h), .load_err(le6h), .expired(ex6h));
  contador_mod_n #(.MODULUS(10), .WIDTH(4), .WRAP_MODE(1)) u_lsd (
    .clk(clk), .clearn(clearn), .en(en), .loadn(loadn), .data(d_lo),
    .count(c_lo), .tc(tc_lo), .zero(z_lo), .load_err(le_lo), .expired(ex_lo));
  contador_mod_n #(.MODULUS(6), .WIDTH(3), .WRAP_MODE(1)) u_msd (
    .clk(clk), .clearn(clearn), .en(tc_lo), .loadn(loadn), .data(d_hi),
    .count(c_hi), .tc(tc_hi), .zero(z_hi), .load_err(le_hi), .expired(ex_hi));

  typedef struct {
    int c6w, c6h, lo, hi;
    bit tc6w, tc6h, tcc, z6w, z6h, le6w, le6h, ex6w, ex6h, lelo, lehi, exlo, exhi;
  } exp_t;
  exp_t q[$];

  int n_total = 0;
  int n_pass = 0;

  // reference state: the cascade is kept as a single seconds value 0..59
  int  m6w = 0, m6h = 0, t = 0;
  bit  e6w = 0, e6h = 0, elo = 0, ehi = 0;
  bit  l6w = 0, l6h = 0, llo = 0, lhi = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  function automatic int clampv(input int d, input int m);
    return d < m ? d : m - 1;
  endfunction

  task automatic model_reset();
    m6w = 0; m6h = 0; t = 0;
    e6w = 0; e6h = 0; elo = 0; ehi = 0;
    l6w = 0; l6h = 0; llo = 0; lhi = 0;
  endtask

  task automatic cyc(input bit e, input bit l, input int v3, input int vlo, input int vhi);
    exp_t x;
    int old;
    @(negedge clk);
    clearn = 1'b1;
    en = e;
    loadn = l;
    d3 = 3'(v3);
    d_lo = 4'(vlo);
    d_hi = 3'(vhi);
    x.c6w = m6w; x.c6h = m6h; x.lo = t % 10; x.hi = t / 10;
    x.tc6w = e && l && m6w == 0;
    x.tc6h = e && l && m6h == 0;
    x.tcc  = e && l && t == 0;
    x.z6w = m6w == 0; x.z6h = m6h == 0;
    x.le6w = l6w; x.le6h = l6h; x.lelo = llo; x.lehi = lhi;
    x.ex6w = e6w; x.ex6h = e6h; x.exlo = elo; x.exhi = ehi;
    q.push_back(x);
    if (!l) begin
      m6w = clampv(v3, 6); m6h = m6w;
      l6w = v3 >= 6; l6h = l6w;
      llo = vlo >= 10; lhi = vhi >= 6;
      t = clampv(vhi, 6) * 10 + clampv(vlo, 10);
      e6w = 0; e6h = 0; elo = 0; ehi = 0;
    end else begin
      l6w = 0; l6h = 0; llo = 0; lhi = 0;
      if (e) begin
        if (m6w == 1) e6w = 1;
        m6w = (m6w + 5) % 6;
        if (m6h == 1) e6h = 1;
        if (m6h > 0) m6h = m6h - 1;
        old = t;
        t = (t + 59) % 60;
        if (old % 10 == 1) elo = 1;
        if (old / 10 == 1 && t / 10 == 0) ehi = 1;
      end
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("wrap_count", int'(c6w), x.c6w);
        check("wrap_tc", int'(tc6w), int'(x.tc6w));
        check("wrap_zero", int'(z6w), int'(x.z6w));
        check("wrap_load_err", int'(le6w), int'(x.le6w));
        check("wrap_expired", int'(ex6w), int'(x.ex6w));
        check("hold_count", int'(c6h), x.c6h);
        check("hold_tc", int'(tc6h), int'(x.tc6h));
        check("hold_zero", int'(z6h), int'(x.z6h));
        check("hold_load_err", int'(le6h), int'(x.le6h));
        check("hold_expired", int'(ex6h), int'(x.ex6h));
        check("lsd_count", int'(c_lo), x.lo);
        check("msd_count", int'(c_hi), x.hi);
        check("msd_tc", int'(tc_hi), int'(x.tcc));
        check("lsd_load_err", int'(le_lo), int'(x.lelo));
        check("msd_load_err", int'(le_hi), int'(x.lehi));
        check("lsd_expired", int'(ex_lo), int'(x.exlo));
        check("msd_expired", int'(ex_hi), int'(x.exhi));
      end
    end
  end

  initial begin : stimulus
    repeat (2) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 5, 9, 5);
    repeat (62) cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 7, 15, 7);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 3, 3, 2);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 2, 2, 0);
    repeat (5) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 4, 4, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 3, 3, 3);
    cyc(0, 1, 0, 0, 0);
    #3 clearn = 1'b0;
    #1;
    check("async_rst_count", int'(c6w), 0);
    check("async_rst_expired", int'(ex6w), 0);
    check("async_rst_load_err", int'(le6w), 0);
    check("async_rst_cascade", int'(c_lo) + int'(c_hi), 0);
    model_reset();
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
    repeat (3) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/contador_mod_n.md
Name: contador_mod_n

Overview:
Parametrised modulo-N down-counter digit for the timer datapath. It is the generalised successor of the fixed mod-6 tens-digit counter.
- Any modulus and width; synchronous load with range clamping; selectable wrap or stop-at-zero; load-error flag; sticky expiry flag.
- Digits cascade by feeding one digit's `tc` into the next digit's `en`, forming multi-digit MM:SS style timers.

Parameters:
- MODULUS, 10, number of states; counts MODULUS-1 down to 0; legal range 2..2^WIDTH.
- WIDTH, 4, bit width of `data` and `count`; elaboration must fail (generate-time $error) if 2^WIDTH < MODULUS.
- WRAP_MODE, 1, 1 = wrap 0 -> MODULUS-1 when enabled; 0 = hold at 0 once reached.

Ports:
- clk  input  1  rising-edge clock
- clearn  input  1  asynchronous active-low reset
- en  input  1  count enable (previous digit's `tc`, or 1 Hz tick for LSD)
- loadn  input  1  synchronous active-low load
- data  input  WIDTH  load value
- count  output  WIDTH  current digit value (registered)
- tc  output  1  terminal count / borrow to next digit (combinational)
- zero  output  1  count == 0 (combinational)
- load_err  output  1  registered one-cycle pulse: last load had data >= MODULUS
- expired  output  1  sticky registered flag: counter reached 0 by counting

Behaviour:
- Reset (clearn = 0, asynchronous): count = 0, load_err = 0, expired = 0. Reset may assert mid-count and overrides everything. First count edge after release behaves as if starting from 0.
- Priority on each rising clk edge, clearn = 1: load > count > hold.
- Load (loadn = 0, independent of en):
  - count <= data if data < MODULUS, else count <= MODULUS-1.
  - load_err <= 1 for that cycle only if clamped; otherwise 0.
  - expired <= 0.
- Count (loadn = 1, en = 1):
  - count > 0: count <= count - 1. If count == 1, expired <= 1.
  - count == 0, WRAP_MODE = 1: count <= MODULUS-1; expired unchanged.
  - count == 0, WRAP_MODE = 0: count holds 0.
- Hold (loadn = 1, en = 0): count unchanged.
- load_err clears to 0 on every edge that is not a clamped load.
- zero = (count == 0).
- tc = en & loadn & zero. Never asserted during a load cycle, so a loading digit does not borrow from its neighbour.
- Latency: count updates one edge after en/loadn sampled; tc/zero have zero latency from count.
- Arithmetic is WIDTH bits, unsigned; no intermediate value may exceed MODULUS-1.

Optional Feature:
Macro `CONTADOR_UPDOWN_EN`.
- Defined: adds port `up` (input, 1). When `up` = 1 and counting:
  - count increments.
  - MODULUS-1 -> 0 in WRAP_MODE = 1; holds at MODULUS-1 in WRAP_MODE = 0.
  - tc = en & loadn & (count == MODULUS-1).
  - expired is set on reaching MODULUS-1 by counting.
  - When `up` = 0, behaviour is exactly as above.
- Undefined: no `up` port; down-only behaviour as specified.

Test Plan (MODULUS=6, WIDTH=3 unless noted):
- Reset then load data=5, en=1 for 7 cycles -> count 5,4,3,2,1,0,5. tc=1 only while count=0 with en=1. expired=1 from the cycle count becomes 0.
- Load data=7 -> count=5, load_err=1 for one cycle then 0. Load data=3 -> count=3, load_err=0.
- WRAP_MODE=0: load 2, en=1 for 5 cycles -> 1,0,0,0,0. tc stays 1 while en=1. A new load of 4 clears expired.
- loadn=0 and en=1 with count=0 on the same edge -> count=data, tc=0 during that cycle. en=0, loadn=1 -> count holds.
- Assert clearn low asynchronously mid-cycle at count=3 -> count=0, expired=0, load_err=0 immediately, without waiting for a clk edge.
- Cascade MODULUS=10 LSD with MODULUS=6 MSD (MSD.en = LSD.tc), load 59, en=1 for 60 cycles -> 58 … 00 then 59. MSD decrements only on LSD 0->9.
